// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared constants and types for the 4-bit registered ALU.
//           Holds the datapath width, the opcode encodings selected by
//           {S1,S0}, and the packed bundle of registered ALU results.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Datapath width; the block is fixed at 4 bits.
    localparam int ALU_W = 4;

    // Opcode encodings, indexed by {S1,S0}.
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // Everything the output register stage holds, kept together so the
    // "clear what the current opcode does not own" rule is a single '0.
    typedef struct packed {
        logic [ALU_W-1:0] sum;
        logic             carry;
        logic             greater;
        logic             lesser;
        logic             equal;
        logic [ALU_W-1:0] and_r;
    } alu_res_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
// Module  : alu_addsub
// Purpose : Combinational ripple-carry adder/subtractor.
//           sub_i = 0 : {cout_o,sum_o} = a_i + b_i
//           sub_i = 1 : {cout_o,sum_o} = a_i + ~b_i + 1  (cout_o = no borrow)
// Ports   :
//   a_i    [ALU_W-1:0] in  : operand A
//   b_i    [ALU_W-1:0] in  : operand B
//   sub_i              in  : 1 selects subtraction
//   sum_o  [ALU_W-1:0] out : sum / difference, modulo 2**ALU_W
//   cout_o             out : carry out of the most significant bit
// Revision: 1.0 - initial release
// ============================================================================
module alu_addsub
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    input  logic             sub_i,
    output logic [ALU_W-1:0] sum_o,
    output logic             cout_o
);

    // Carry chain; the carry-in doubles as the "+1" of two's-complement
    // subtraction, so the same sub_i bit that inverts B also seeds it.
    logic [ALU_W:0] w_c;

    assign w_c[0] = sub_i;

    for (genvar gi = 0; gi < ALU_W; gi++) begin : g_bit
        logic w_b;
        assign w_b         = b_i[gi] ^ sub_i;
        assign sum_o[gi]   = a_i[gi] ^ w_b ^ w_c[gi];
        assign w_c[gi + 1] = (a_i[gi] & w_b) | (w_c[gi] & (a_i[gi] ^ w_b));
    end

    assign cout_o = w_c[ALU_W];

endmodule : alu_addsub
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module  : alu
// Purpose : Registered 4-bit ALU. Opcode {S1,S0} selects AND, ADD, CMP or
//           SUB; operands are sampled on the rising edge of clk and every
//           result is a flop, giving a fixed latency of one cycle. Outputs
//           that do not belong to the selected operation register as 0.
// Ports   :
//   clk             in  : rising-edge clock
//   rst_n           in  : asynchronous active-low reset, clears all outputs
//   S0, S1          in  : opcode bits (00 AND, 01 ADD, 10 CMP, 11 SUB)
//   A, B      [3:0] in  : unsigned operands
//   addersubtractor [3:0] out : sum or difference
//   carry           out : adder carry-out (for SUB: 1 = no borrow)
//   greater         out : A > B  (CMP only)
//   lesser          out : A < B  (CMP only)
//   equal           out : A == B (CMP only)
//   And       [3:0] out : A & B  (AND only)
// Revision: 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             S0,
    input  logic             S1,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    output logic [ALU_W-1:0] addersubtractor,
    output logic             carry,
    output logic             greater,
    output logic             lesser,
    output logic             equal,
    output logic [ALU_W-1:0] And
);

    logic [1:0]       w_op;
    logic             w_sub;
    logic [ALU_W-1:0] w_sum;
    logic             w_cout;

    alu_res_t res_d;
    alu_res_t res_q;

    assign w_op  = {S1, S0};
    assign w_sub = (w_op == OP_SUB);

    // ADD and SUB share one adder; only the invert/carry-in control differs.
    alu_addsub u_addsub (
        .a_i    (A),
        .b_i    (B),
        .sub_i  (w_sub),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    // Next-state selection. Starting from all-zero means every field the
    // opcode does not own is cleared without listing it per branch.
    always_comb begin
        res_d = '0;
        case (w_op)
            OP_AND: begin
                res_d.and_r = A & B;
            end
            OP_ADD, OP_SUB: begin
                res_d.sum   = w_sum;
                res_d.carry = w_cout;
            end
            OP_CMP: begin
                res_d.greater = (A > B);
                res_d.lesser  = (A < B);
                res_d.equal   = (A == B);
            end
            default: begin
                res_d = '0;
            end
        endcase
    end

    // Single output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign addersubtractor = res_q.sum;
    assign carry           = res_q.carry;
    assign greater         = res_q.greater;
    assign lesser          = res_q.lesser;
    assign equal           = res_q.equal;
    assign And             = res_q.and_r;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu
// Purpose : Self-checking bench for the registered 4-bit ALU. Directed
//           vectors followed by random operations, each compared against an
//           arithmetic reference model; also covers reset, one-cycle
//           latency and the absence of any combinational input-to-output path.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic       S0;
    logic       S1;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] addersubtractor;
    logic       carry;
    logic       greater;
    logic       lesser;
    logic       equal;
    logic [3:0] And;

    // Observed vector: {sum[3:0], carry, greater, lesser, equal, and[3:0]}
    logic [11:0] obs;
    logic [11:0] prev_exp;

    int errors = 0;
    int checks = 0;

    alu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .S0              (S0),
        .S1              (S1),
        .A               (A),
        .B               (B),
        .addersubtractor (addersubtractor),
        .carry           (carry),
        .greater         (greater),
        .lesser          (lesser),
        .equal           (equal),
        .And             (And)
    );

    assign obs = {addersubtractor, carry, greater, lesser, equal, And};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from the operation definitions with integer math.
    function automatic logic [11:0] model(input int op, input int a, input int b);
        int         s;
        logic [3:0] r;
        logic       c;
        logic       g;
        logic       l;
        logic       e;
        logic [3:0] an;
        r = 4'd0; c = 1'b0; g = 1'b0; l = 1'b0; e = 1'b0; an = 4'd0;
        case (op)
            0: an = 4'(a & b);
            1: begin
                s = a + b;
                r = 4'(s % 16);
                c = (s > 15);
            end
            2: begin
                g = (a > b);
                l = (a < b);
                e = (a == b);
            end
            default: begin
                r = 4'((a - b + 16) % 16);
                c = (a >= b);
            end
        endcase
        return {r, c, g, l, e, an};
    endfunction

    task automatic check(input string tag, input logic [11:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    // Drive one operation just after an edge, confirm the outputs still hold
    // the previous result mid-cycle, then check the new result after the edge.
    task automatic apply(input string tag, input int op, input int a, input int b);
        logic [11:0] exp;
        {S1, S0} = 2'(op);
        A        = 4'(a);
        B        = 4'(b);
        exp      = model(op, a, b);
        #3;
        check({tag, "_hold"}, prev_exp);
        @(posedge clk);
        #1;
        check(tag, exp);
        prev_exp = exp;
    endtask

    initial begin
        rst_n = 1'b1;
        {S1, S0} = 2'b00;
        A = 4'd0;
        B = 4'd0;
        prev_exp = 12'h000;

        // Reset, asserted asynchronously and held across edges.
        #1 rst_n = 1'b0;
        #1;
        check("reset_async", 12'h000);
        A = 4'hF; B = 4'hF; {S1, S0} = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", 12'h000);
        A = 4'd0; B = 4'd0; {S1, S0} = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 12'h000);

        // Directed vectors.
        apply("and_0",  0, 4'b0011, 4'b1100);
        apply("and_1",  0, 4'b1101, 4'b1100);
        apply("add_0",  1, 4'b0100, 4'b1011);
        apply("add_1",  1, 4'b0110, 4'b1111);
        apply("sub_0",  3, 4'b1101, 4'b1001);
        apply("sub_1",  3, 4'b0110, 4'b1101);
        apply("sub_2",  3, 4'b0000, 4'b0000);
        apply("sub_3",  3, 4'b1011, 4'b1010);
        apply("cmp_eq", 2, 4'b1000, 4'b1000);
        apply("cmp_gt", 2, 4'b1101, 4'b1100);
        apply("cmp_lt", 2, 4'b0011, 4'b1100);
        apply("add_max", 1, 15, 15);
        apply("sub_wrap", 3, 0, 15);

        // Reset dropped between edges while an ADD result is in flight.
        apply("add_pre_rst", 1, 4'b0100, 4'b1011);
        {S1, S0} = 2'b01;
        A = 4'b0110;
        B = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid", 12'h000);
        #1 rst_n = 1'b1;
        #1;
        check("reset_mid_hold", 12'h000);
        @(posedge clk);
        #1;
        check("reset_recover", model(1, 6, 15));
        prev_exp = model(1, 6, 15);

        // Random operations, operands changing every cycle.
        for (int i = 0; i < 200; i++) begin
            apply("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_alu
`default_nettype wire
